// File: rtl/crc24a_pkg.sv
// ----------------------------------------------------------------------------
// crc24a_pkg
// Shared constants and types for the CRC24A checker and encoder.
//   CRC24_POLY : generator polynomial (x^24 term implicit)
//   CRC24_INIT : initial value of the running CRC register
//   CRC_BYTES  : number of CRC bytes trailing each frame
//   LEN_W      : width of the saturating frame byte counter
// ----------------------------------------------------------------------------
package crc24a_pkg;

  localparam logic [23:0] CRC24_POLY = 24'h864CFB;
  localparam logic [23:0] CRC24_INIT = 24'h000000;
  localparam int          CRC_BYTES  = 3;
  localparam int          LEN_W      = 16;

  // Delay-line occupancy counter must represent 0..CRC_BYTES.
  localparam int          FILL_W     = $clog2(CRC_BYTES + 1);

  typedef logic [23:0]      crc_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef logic [FILL_W-1:0] fill_t;

  // Frame verdict as presented on the status channel.
  typedef struct packed {
    logic crc_ok;
    logic len_err;
    len_t len;
  } sts_t;

endpackage

// File: rtl/crc24a_step.sv
// ----------------------------------------------------------------------------
// crc24a_step
// Combinational byte-wise CRC24A update, MSB first, no reflection.
// Shared between the checker and the encoder.
//   crc       in  24  current CRC register
//   data_byte in   8  byte being absorbed
//   crc_next  out 24  CRC register after absorbing data_byte
// ----------------------------------------------------------------------------
module crc24a_step
  import crc24a_pkg::*;
(
  input  logic [23:0] crc,
  input  logic [7:0]  data_byte,
  output logic [23:0] crc_next
);

  crc_t acc;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each loop iteration sees
    // the previous iteration's result; acc is assigned first so no latch forms.
    acc = crc ^ {data_byte, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      if (acc[23]) acc = {acc[22:0], 1'b0} ^ CRC24_POLY;
      else         acc = {acc[22:0], 1'b0};
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc24a_check.sv
// ----------------------------------------------------------------------------
// crc24a_check
// Streaming CRC24A frame checker. Every accepted byte (payload plus the three
// trailing CRC bytes) is folded into a running CRC. A three-byte delay line
// holds back the newest bytes so the CRC trailer is stripped from the output
// stream; the byte that finally leaves the delay line is tagged tlast when the
// byte that displaced it is the input tlast. One cycle after the tlast byte is
// accepted a status word (crc_ok, len_err, payload length) is presented and
// held until consumed; input is stalled while it is pending.
//
// Ports
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   s_axis_t{data,valid,ready,last}  received bytes (payload + 3 CRC bytes)
//   m_axis_t{data,valid,ready,last}  payload bytes, CRC stripped
//   sts_valid / sts_ready     status handshake
//   sts_crc_ok                1 = CRC residue zero
//   sts_len_err               1 = frame shorter than CRC_BYTES+1 bytes
//   sts_len                   payload byte count, saturating
// ----------------------------------------------------------------------------
module crc24a_check
  import crc24a_pkg::*;
(
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             sts_valid,
  input  logic             sts_ready,
  output logic             sts_crc_ok,
  output logic             sts_len_err,
  output logic [LEN_W-1:0] sts_len
);

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release follows two ap_clk
  // edges so every flop leaves reset in the same cycle.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       core_rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    // NOTE: clocked state uses non-blocking '<=' so all flops update together
    // from values sampled at the same edge.
    if (!ap_rst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign core_rst_n = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  crc_t       crc_q;
  len_t       count_q;
  fill_t      fill_q;
  logic [7:0] dline_q [CRC_BYTES];   // [0] is the oldest byte

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  crc_t crc_next;
  len_t count_inc;
  logic dline_full;
  logic accept;
  logic push;
  logic long_enough;
  sts_t sts_next;

  crc24a_step u_step (
    .crc       (crc_q),
    .data_byte (s_axis_tdata),
    .crc_next  (crc_next)
  );

  assign dline_full = (fill_q == FILL_W'(CRC_BYTES));

  // Input is taken unless a verdict is waiting, or the delay line is full and
  // the output register cannot make room this cycle. Depends only on
  // registered state and the two downstream ready inputs.
  assign s_axis_tready = core_rst_n
                       & !(sts_valid & !sts_ready)
                       & (!dline_full | !m_axis_tvalid | m_axis_tready);

  assign accept = s_axis_tvalid & s_axis_tready;

  // A full delay line means the oldest byte is payload and must move on.
  assign push   = accept & dline_full;

  assign count_inc   = (count_q == '1) ? count_q : count_q + LEN_W'(1);
  assign long_enough = (count_inc >= LEN_W'(CRC_BYTES + 1));

  always_comb begin
    sts_next         = '0;
    sts_next.len_err = !long_enough;
    sts_next.crc_ok  = long_enough && (crc_next == 24'h000000);
    sts_next.len     = long_enough ? count_inc - LEN_W'(CRC_BYTES) : '0;
  end

  // --------------------------------------------------------------------------
  // Frame bookkeeping: CRC, byte count, delay-line fill. All three restart in
  // the tlast cycle so the next frame may follow without a gap.
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      crc_q   <= CRC24_INIT;
      count_q <= '0;
      fill_q  <= '0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        crc_q   <= CRC24_INIT;
        count_q <= '0;
        fill_q  <= '0;
      end else begin
        crc_q   <= crc_next;
        count_q <= count_inc;
        if (!dline_full) fill_q <= fill_q + FILL_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Delay-line storage. Contents are only ever read below the fill mark, so
  // stale data after reset or a flush is harmless.
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    // NOTE: this storage array is deliberately not reset; fill_q qualifies it.
    if (accept && !s_axis_tlast) begin
      if (dline_full) begin
        dline_q[0] <= dline_q[1];
        dline_q[1] <= dline_q[2];
        dline_q[2] <= s_axis_tdata;
      end else begin
        dline_q[fill_q] <= s_axis_tdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register. A push can only occur when the register is empty or
  // being drained (guaranteed by s_axis_tready), so held data never changes.
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (push) begin
      m_axis_tdata  <= dline_q[0];
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Status register: loaded from the tlast byte, held until consumed. A new
  // load can coincide with consumption of the previous status.
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      sts_valid   <= 1'b0;
      sts_crc_ok  <= 1'b0;
      sts_len_err <= 1'b0;
      sts_len     <= '0;
    end else if (accept && s_axis_tlast) begin
      sts_valid   <= 1'b1;
      sts_crc_ok  <= sts_next.crc_ok;
      sts_len_err <= sts_next.len_err;
      sts_len     <= sts_next.len;
    end else if (sts_ready) begin
      sts_valid   <= 1'b0;
    end
  end

endmodule
